// File: rtl/operand_ready_unit_pkg.sv
// Shared constants and operand-mode encoding for the dispatch-stage
// operand ready unit.
package operand_ready_unit_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int WB_WIDTH             = 2;

    // Three bits leave encodings 4..7 unused; those resolve to an invalid operand.
    typedef enum logic [2:0] {
        OP_REG  = 3'd0,
        OP_IMM  = 3'd1,
        OP_PC   = 3'd2,
        OP_ZERO = 3'd3
    } op_type_t;

    localparam int OP_TYPE_WIDTH = $bits(op_type_t);

endpackage

// File: rtl/operand_ready_unit_busy_table.sv
// Physical-register busy table: one flop per preg, set on rename
// allocation, cleared on writeback, wiped on flush. Also keeps a registered
// popcount that tracks the table with zero skew.
module operand_ready_unit_busy_table
    import operand_ready_unit_pkg::*;
#(
    parameter int DW     = operand_ready_unit_pkg::DISPATCH_WIDTH,
    parameter int WBW    = operand_ready_unit_pkg::WB_WIDTH,
    parameter int NREGS  = operand_ready_unit_pkg::PHYS_REGS,
    parameter int ADDR_W = operand_ready_unit_pkg::PHYS_REGS_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DW-1:0]                alloc_valid,
    input  logic [DW-1:0][ADDR_W-1:0]    alloc_preg,
    input  logic [WBW-1:0]               wb_valid,
    input  logic [WBW-1:0][ADDR_W-1:0]   wb_preg,
    output logic [NREGS-1:0]             busy,
    output logic [ADDR_W:0]              busy_count
);

    localparam int CNT_W = ADDR_W + 1;

    logic [NREGS-1:0] busy_next;
    logic [CNT_W-1:0] count_next;

    // Next-state table: clears first, then sets so a same-cycle alloc wins,
    // then p0 pinned idle and flush overriding everything.
    always_comb begin
        // NOTE: every always_comb output gets a full default up front so no path can infer a latch.
        busy_next = busy;
        for (int j = 0; j < WBW; j++) begin
            if (wb_valid[j]) begin
                busy_next[wb_preg[j]] = 1'b0;
            end
        end
        for (int i = 0; i < DW; i++) begin
            if (alloc_valid[i]) begin
                busy_next[alloc_preg[i]] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
        if (flush) begin
            busy_next = '0;
        end
    end

    // Popcount of the next-state table so busy_count lands with the table.
    always_comb begin
        count_next = '0;
        for (int p = 0; p < NREGS; p++) begin
            count_next = count_next + CNT_W'(busy_next[p]);
        end
    end

    // Table and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the table is a plain flop vector, not a RAM, so resetting every entry is legal and cheap;
        // nonblocking assignments keep all bits updating from the same pre-edge values.
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/operand_ready_unit.sv
// Dispatch-stage operand resolution: selects register tag, immediate, PC
// or zero per source and computes the operand-ready bit from the busy
// table, same-cycle writeback bypass and older-in-group producers.
module operand_ready_unit
    import operand_ready_unit_pkg::*;
#(
    parameter int DISPATCH_WIDTH       = operand_ready_unit_pkg::DISPATCH_WIDTH,
    parameter int NUM_SRC              = 2,
    parameter int PHYS_REGS            = operand_ready_unit_pkg::PHYS_REGS,
    parameter int PHYS_REGS_ADDR_WIDTH = operand_ready_unit_pkg::PHYS_REGS_ADDR_WIDTH,
    parameter int WB_WIDTH             = operand_ready_unit_pkg::WB_WIDTH
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    flush,
    input  logic [DISPATCH_WIDTH-1:0]                               alloc_valid,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]     alloc_preg,
    input  logic [WB_WIDTH-1:0]                                     wb_valid,
    input  logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]           wb_preg,
    input  logic [DISPATCH_WIDTH-1:0][NUM_SRC-1:0][OP_TYPE_WIDTH-1:0] src_type,
    input  logic [DISPATCH_WIDTH-1:0][NUM_SRC-1:0][PHYS_REGS_ADDR_WIDTH-1:0] src_preg,
    input  logic [DISPATCH_WIDTH-1:0][31:0]                         imm,
    input  logic [DISPATCH_WIDTH-1:0][31:0]                         pc,
    output logic [DISPATCH_WIDTH-1:0][NUM_SRC-1:0][31:0]            operand,
    output logic [DISPATCH_WIDTH-1:0][NUM_SRC-1:0]                  operand_valid,
    output logic [PHYS_REGS_ADDR_WIDTH:0]                           busy_count
);

    logic [PHYS_REGS-1:0] busy;

    operand_ready_unit_busy_table #(
        .DW     (DISPATCH_WIDTH),
        .WBW    (WB_WIDTH),
        .NREGS  (PHYS_REGS),
        .ADDR_W (PHYS_REGS_ADDR_WIDTH)
    ) u_busy_table (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .wb_valid    (wb_valid),
        .wb_preg     (wb_preg),
        .busy        (busy),
        .busy_count  (busy_count)
    );

    // Per-bank, per-source operand mux and ready resolution.
    always_comb begin
        logic [PHYS_REGS_ADDR_WIDTH-1:0] tag;
        logic                            older_alloc;
        logic                            bypass;
        logic                            ready;
        operand       = '0;
        operand_valid = '0;
        tag           = '0;
        older_alloc   = 1'b0;
        bypass        = 1'b0;
        ready         = 1'b0;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                tag         = src_preg[b][s];
                // Only strictly older banks count; a bank's own alloc (rd == rs) must not stall it.
                older_alloc = 1'b0;
                for (int i = 0; i < b; i++) begin
                    if (alloc_valid[i] && alloc_preg[i] == tag) begin
                        older_alloc = 1'b1;
                    end
                end
                bypass = 1'b0;
                for (int j = 0; j < WB_WIDTH; j++) begin
                    if (wb_valid[j] && wb_preg[j] == tag) begin
                        bypass = 1'b1;
                    end
                end
                if (tag == '0) begin
                    ready = 1'b1;
                end else if (older_alloc) begin
                    ready = 1'b0;
                end else if (bypass) begin
                    ready = 1'b1;
                end else begin
                    ready = !busy[tag];
                end

                case (src_type[b][s])
                    OP_REG: begin
                        operand[b][s]       = 32'(tag);
                        operand_valid[b][s] = ready;
                    end
                    OP_IMM: begin
                        operand[b][s]       = imm[b];
                        operand_valid[b][s] = 1'b1;
                    end
                    OP_PC: begin
                        operand[b][s]       = pc[b];
                        operand_valid[b][s] = 1'b1;
                    end
                    OP_ZERO: begin
                        operand[b][s]       = '0;
                        operand_valid[b][s] = 1'b1;
                    end
                    default: begin
                        operand[b][s]       = '0;
                        operand_valid[b][s] = 1'b0;
                    end
                endcase
            end
        end
    end

    // The freelist never hands the same non-zero preg to two banks in one cycle.
    logic dup_alloc;
    always_comb begin
        dup_alloc = 1'b0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            for (int k = i + 1; k < DISPATCH_WIDTH; k++) begin
                if (alloc_valid[i] && alloc_valid[k] &&
                    alloc_preg[i] == alloc_preg[k] && alloc_preg[i] != '0) begin
                    dup_alloc = 1'b1;
                end
            end
        end
    end

    a_no_dup_alloc: assert property (@(posedge clk) disable iff (rst) !dup_alloc);

endmodule

// File: tb/tb_operand_ready_unit.sv
// Scoreboard bench for operand_ready_unit: each issued cycle pushes the
// reference expectation, a negedge monitor pops and compares.
module tb_operand_ready_unit;
    import operand_ready_unit_pkg::*;

    localparam int DW  = DISPATCH_WIDTH;
    localparam int NS  = 2;
    localparam int NP  = PHYS_REGS;
    localparam int AW  = PHYS_REGS_ADDR_WIDTH;
    localparam int WBW = WB_WIDTH;
    localparam int TW  = OP_TYPE_WIDTH;

    logic                          clk;
    logic                          rst;
    logic                          flush;
    logic [DW-1:0]                 alloc_valid;
    logic [DW-1:0][AW-1:0]         alloc_preg;
    logic [WBW-1:0]                wb_valid;
    logic [WBW-1:0][AW-1:0]        wb_preg;
    logic [DW-1:0][NS-1:0][TW-1:0] src_type;
    logic [DW-1:0][NS-1:0][AW-1:0] src_preg;
    logic [DW-1:0][31:0]           imm;
    logic [DW-1:0][31:0]           pc;
    logic [DW-1:0][NS-1:0][31:0]   operand;
    logic [DW-1:0][NS-1:0]         operand_valid;
    logic [AW:0]                   busy_count;

    operand_ready_unit #(
        .DISPATCH_WIDTH       (DW),
        .NUM_SRC              (NS),
        .PHYS_REGS            (NP),
        .PHYS_REGS_ADDR_WIDTH (AW),
        .WB_WIDTH             (WBW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_preg    (alloc_preg),
        .wb_valid      (wb_valid),
        .wb_preg       (wb_preg),
        .src_type      (src_type),
        .src_preg      (src_preg),
        .imm           (imm),
        .pc            (pc),
        .operand       (operand),
        .operand_valid (operand_valid),
        .busy_count    (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0][NS-1:0][31:0] op;
        logic [DW-1:0][NS-1:0]       vld;
        logic [AW:0]                 cnt;
        string                       tag;
    } exp_t;

    exp_t sb_q[$];
    bit   model_busy[NP];
    int   passed;
    int   total;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference readiness straight from the first-match rule list.
    function automatic bit model_ready(int b, logic [AW-1:0] tag);
        if (tag == 0) return 1'b1;
        for (int i = 0; i < b; i++)
            if (alloc_valid[i] && alloc_preg[i] == tag) return 1'b0;
        for (int j = 0; j < WBW; j++)
            if (wb_valid[j] && wb_preg[j] == tag) return 1'b1;
        return !model_busy[tag];
    endfunction

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0;
        alloc_valid = '0; alloc_preg = '0;
        wb_valid = '0; wb_preg = '0;
        src_type = '0; src_preg = '0;
        imm = '0; pc = '0;
    endtask

    task automatic set_src(int b, int s, op_type_t t, int preg);
        src_type[b][s] = t;
        src_preg[b][s] = AW'(preg);
    endtask

    task automatic do_alloc(int b, int preg);
        alloc_valid[b] = 1'b1;
        alloc_preg[b]  = AW'(preg);
    endtask

    task automatic do_wb(int j, int preg);
        wb_valid[j] = 1'b1;
        wb_preg[j]  = AW'(preg);
    endtask

    // Called with inputs settled just after a rising edge: records the
    // expected outputs for this cycle, advances the model, waits one cycle.
    task automatic issue(string tag);
        exp_t e;
        int   cnt;
        cnt = 0;
        for (int p = 0; p < NP; p++) cnt += int'(model_busy[p]);
        e.tag = tag;
        e.cnt = (AW+1)'(cnt);
        e.op  = '0;
        e.vld = '0;
        for (int b = 0; b < DW; b++) begin
            for (int s = 0; s < NS; s++) begin
                case (src_type[b][s])
                    OP_REG:  begin e.op[b][s] = 32'(src_preg[b][s]); e.vld[b][s] = model_ready(b, src_preg[b][s]); end
                    OP_IMM:  begin e.op[b][s] = imm[b]; e.vld[b][s] = 1'b1; end
                    OP_PC:   begin e.op[b][s] = pc[b];  e.vld[b][s] = 1'b1; end
                    OP_ZERO: begin e.op[b][s] = 32'd0;  e.vld[b][s] = 1'b1; end
                    default: begin e.op[b][s] = 32'd0;  e.vld[b][s] = 1'b0; end
                endcase
            end
        end
        sb_q.push_back(e);
        if (rst || flush) begin
            for (int p = 0; p < NP; p++) model_busy[p] = 1'b0;
        end else begin
            for (int j = 0; j < WBW; j++) if (wb_valid[j]) model_busy[wb_preg[j]] = 1'b0;
            for (int i = 0; i < DW; i++) if (alloc_valid[i]) model_busy[alloc_preg[i]] = 1'b1;
            model_busy[0] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output of each issued cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                for (int b = 0; b < DW; b++) begin
                    for (int s = 0; s < NS; s++) begin
                        check($sformatf("%s operand b%0d s%0d", e.tag, b, s), operand[b][s], e.op[b][s]);
                        check($sformatf("%s valid b%0d s%0d", e.tag, b, s), 32'(operand_valid[b][s]), 32'(e.vld[b][s]));
                    end
                end
                check($sformatf("%s busy_count", e.tag), 32'(busy_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        passed = 0;
        total  = 0;
        for (int p = 0; p < NP; p++) model_busy[p] = 1'b0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue("reset");

        clear_inputs(); set_src(0, 0, OP_REG, 7); issue("idle_p7");

        clear_inputs(); do_alloc(0, 9); issue("alloc_p9");
        clear_inputs(); set_src(0, 0, OP_REG, 9); issue("busy_p9");
        clear_inputs(); set_src(0, 0, OP_REG, 9); issue("still_busy_p9");
        clear_inputs(); set_src(0, 0, OP_REG, 9); do_wb(0, 9); issue("bypass_p9");
        clear_inputs(); set_src(0, 0, OP_REG, 9); issue("table_p9");

        clear_inputs(); do_alloc(0, 12); set_src(1, 0, OP_REG, 12); set_src(0, 0, OP_REG, 12);
        set_src(0, 1, OP_REG, 12); issue("intra_group_p12");
        clear_inputs(); do_wb(1, 12); set_src(1, 1, OP_REG, 12); issue("wb_p12");

        clear_inputs(); do_alloc(0, 20); do_wb(1, 20); issue("alloc_wb_p20");
        clear_inputs(); set_src(0, 0, OP_REG, 20); do_alloc(0, 0); set_src(1, 0, OP_REG, 0); issue("alloc_p0");
        clear_inputs(); set_src(0, 1, OP_REG, 20); set_src(1, 1, OP_REG, 0); issue("after_p0");
        clear_inputs(); do_wb(0, 20); issue("wb_p20");

        clear_inputs(); imm[1] = 32'hFFFF_F800; pc[1] = 32'h8000_0010;
        set_src(1, 0, OP_IMM, 0); set_src(1, 1, OP_PC, 0); issue("imm_pc");
        clear_inputs(); imm[1] = 32'hFFFF_F800; pc[1] = 32'h8000_0010;
        set_src(1, 0, OP_ZERO, 5); src_type[1][1] = 3'd5; src_preg[1][1] = 6'd1; issue("zero_undef");

        clear_inputs(); do_alloc(0, 3); do_alloc(1, 4); issue("busy_p3_p4");
        clear_inputs(); do_alloc(0, 5); issue("busy_p5");
        clear_inputs(); set_src(0, 0, OP_REG, 4); issue("count_three");
        clear_inputs(); flush = 1'b1; do_alloc(0, 6); set_src(1, 0, OP_REG, 3); issue("flush_alloc_p6");
        clear_inputs(); set_src(0, 0, OP_REG, 6); set_src(0, 1, OP_REG, 3); issue("after_flush");
        clear_inputs(); do_alloc(0, 3); issue("rebusy_p3");
        clear_inputs(); rst = 1'b1; do_alloc(1, 8); set_src(0, 0, OP_REG, 3); issue("mid_reset");
        clear_inputs(); set_src(0, 0, OP_REG, 3); set_src(1, 0, OP_REG, 8); issue("after_reset");

        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 5);
            for (int i = 0; i < DW; i++) begin
                alloc_valid[i] = 1'($urandom_range(0, 1));
                alloc_preg[i]  = AW'($urandom_range(0, 7) * DW + i);
            end
            for (int j = 0; j < WBW; j++) begin
                wb_valid[j] = 1'($urandom_range(0, 1));
                wb_preg[j]  = AW'($urandom_range(0, 15));
            end
            for (int b = 0; b < DW; b++) begin
                imm[b] = $urandom;
                pc[b]  = $urandom;
                for (int s = 0; s < NS; s++) begin
                    src_type[b][s] = ($urandom_range(0, 9) < 6) ? TW'(OP_REG) : TW'($urandom_range(1, 7));
                    src_preg[b][s] = AW'($urandom_range(0, 15));
                end
            end
            issue($sformatf("rand%0d", n));
        end

        clear_inputs();
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end else begin
            passed++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
